// File: rtl/tx_pwr_ctrl_pkg.sv
// Shared definitions for the TX/RX power-up controllers: state encoding,
// default timing constants and the counter-width helper.
package tx_pwr_ctrl_pkg;

    // Sequencer states, shared with the receiver-side controller.
    typedef enum logic [2:0] {
        OFF     = 3'd0,
        BIAS    = 3'd1,
        PLL     = 3'd2,
        RAMP_UP = 3'd3,
        ON      = 3'd4,
        RAMP_DN = 3'd5,
        FAULT   = 3'd6
    } pwr_state_e;

    // Default timing, in CLK cycles (5 MHz nominal clock).
    localparam int T_BIAS_DEF    = 20;
    localparam int T_LOCK_DEF    = 64;
    localparam int RAMP_STEP_DEF = 4;
    localparam int RAMP_W_DEF    = 4;

    // Width of a counter that must hold the largest of three cycle counts.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/tx_pwr_ctrl_sync2.sv
// Two-flop level synchroniser for asynchronous power-up requests.
// Reset clears both flops so a request is never seen during reset.
module tx_pwr_ctrl_sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Shift the asynchronous level through two flops.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/tx_pwr_ctrl.sv
// Transmitter power-up sequencer: bias -> PLL lock -> stepped PA ramp -> ready.
// Power-down and lock loss ramp the PA back to zero before the chain is
// disabled; lock timeout and lock loss end in FAULT until the request drops.
// All outputs are registered and decoded from the next state, so they move
// on the same edge as the state register.
module tx_pwr_ctrl
    import tx_pwr_ctrl_pkg::*;
#(
    parameter int T_BIAS    = T_BIAS_DEF,
    parameter int T_LOCK    = T_LOCK_DEF,
    parameter int RAMP_STEP = RAMP_STEP_DEF,
    parameter int RAMP_W    = RAMP_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              pu_tx_i,
    input  logic              lock_i,
    output logic              en_bias_o,
    output logic              en_pll_o,
    output logic              en_pa_o,
    output logic [RAMP_W-1:0] pa_ramp_o,
    output logic              rdy_tx_o,
    output logic              err_tx_o,
    output logic [2:0]        state_o
);

    localparam int CNT_W = cnt_width(T_BIAS, T_LOCK, RAMP_STEP);

    // Counter compare points. BIAS leaves on its T_BIAS-th cycle; PLL gives
    // up one cycle later than that rule would suggest (timeout after T_LOCK
    // full cycles of waiting, i.e. on the T_LOCK+1-th edge).
    localparam logic [CNT_W-1:0]  BIAS_LAST = CNT_W'(T_BIAS - 1);
    localparam logic [CNT_W-1:0]  LOCK_LAST = CNT_W'(T_LOCK);
    localparam logic [CNT_W-1:0]  STEP_LAST = CNT_W'(RAMP_STEP - 1);
    localparam logic [RAMP_W-1:0] RAMP_MAX  = '1;
    localparam logic [RAMP_W-1:0] RAMP_PEN  = RAMP_MAX - 1'b1;
    localparam logic [RAMP_W-1:0] RAMP_ONE  = RAMP_W'(1);

    pwr_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RAMP_W-1:0] ramp_q, ramp_d;
    logic              err_pend_q, err_pend_d;
    logic              en_bias_q, en_pll_q, en_pa_q, rdy_q, err_q;
    logic              pu_s;
    logic              step;

    tx_pwr_ctrl_sync2 u_sync_pu (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (pu_tx_i),
        .q_o   (pu_s)
    );

    assign step = (cnt_q == STEP_LAST);

    // Next-state, shared cycle counter, ramp level and pending-error logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        ramp_d     = ramp_q;
        err_pend_d = err_pend_q;
        case (state_q)
            OFF: begin
                cnt_d  = '0;
                ramp_d = '0;
                if (pu_s) state_d = BIAS;
            end
            BIAS: begin
                if (!pu_s)                  state_d = OFF;
                else if (cnt_q == BIAS_LAST) state_d = PLL;
            end
            PLL: begin
                ramp_d = '0;
                if (!pu_s)                  state_d = OFF;
                else if (lock_i)            state_d = RAMP_UP;
                else if (cnt_q == LOCK_LAST) state_d = FAULT;
            end
            RAMP_UP: begin
                // Lock loss wins over a dropped request; the ramp holds.
                if (!lock_i) begin
                    err_pend_d = 1'b1;
                    state_d    = RAMP_DN;
                end else if (!pu_s) begin
                    state_d = RAMP_DN;
                end else if (step) begin
                    cnt_d = '0;
                    if (ramp_q != RAMP_MAX) ramp_d = ramp_q + 1'b1;
                    if (ramp_q >= RAMP_PEN) state_d = ON;
                end
            end
            ON: begin
                cnt_d  = '0;
                ramp_d = RAMP_MAX;
                if (!lock_i) begin
                    err_pend_d = 1'b1;
                    state_d    = RAMP_DN;
                end else if (!pu_s) begin
                    state_d = RAMP_DN;
                end
            end
            RAMP_DN: begin
                // A re-asserted request is ignored until the ramp is done.
                if (ramp_q == '0) begin
                    state_d = err_pend_q ? FAULT : OFF;
                end else if (step) begin
                    cnt_d  = '0;
                    ramp_d = ramp_q - 1'b1;
                    if (ramp_q == RAMP_ONE) state_d = err_pend_q ? FAULT : OFF;
                end
            end
            FAULT: begin
                cnt_d  = '0;
                ramp_d = '0;
                if (!pu_s) state_d = OFF;
            end
            default: begin
                cnt_d   = '0;
                ramp_d  = '0;
                state_d = OFF;
            end
        endcase
        if (state_d != state_q) cnt_d = '0;
        if (state_d == OFF)     err_pend_d = 1'b0;
    end

    // State, datapath and output registers; outputs decode the next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= OFF;
            cnt_q      <= '0;
            ramp_q     <= '0;
            err_pend_q <= 1'b0;
            en_bias_q  <= 1'b0;
            en_pll_q   <= 1'b0;
            en_pa_q    <= 1'b0;
            rdy_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ramp_q     <= ramp_d;
            err_pend_q <= err_pend_d;
            en_bias_q  <= (state_d == BIAS) || (state_d == PLL) || (state_d == RAMP_UP) ||
                          (state_d == ON) || (state_d == RAMP_DN);
            en_pll_q   <= (state_d == PLL) || (state_d == RAMP_UP) ||
                          (state_d == ON) || (state_d == RAMP_DN);
            en_pa_q    <= (state_d == RAMP_UP) || (state_d == ON) || (state_d == RAMP_DN);
            rdy_q      <= (state_d == ON);
            err_q      <= (state_d == FAULT);
        end
    end

    assign en_bias_o = en_bias_q;
    assign en_pll_o  = en_pll_q;
    assign en_pa_o   = en_pa_q;
    assign pa_ramp_o = ramp_q;
    assign rdy_tx_o  = rdy_q;
    assign err_tx_o  = err_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_tx_pwr_ctrl.sv
// Bench for tx_pwr_ctrl with default timing (T_BIAS=20, T_LOCK=64,
// RAMP_STEP=4, RAMP_W=4). Edge numbers in comments count rising edges
// after the request is applied.
module tb_tx_pwr_ctrl;
    import tx_pwr_ctrl_pkg::*;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pu = 1'b0;
    logic       lock = 1'b0;
    logic       en_bias, en_pll, en_pa, rdy, err;
    logic [3:0] ramp;
    logic [2:0] state;

    always #5 clk = ~clk;

    tx_pwr_ctrl dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .pu_tx_i   (pu),
        .lock_i    (lock),
        .en_bias_o (en_bias),
        .en_pll_o  (en_pll),
        .en_pa_o   (en_pa),
        .pa_ramp_o (ramp),
        .rdy_tx_o  (rdy),
        .err_tx_o  (err),
        .state_o   (state)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst  = 1'b1;
        pu   = 1'b0;
        lock = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input int b, input int p, input int a,
                            input int r, input int y, input int e);
        chk({tag, ".en_bias"}, int'(en_bias), b);
        chk({tag, ".en_pll"},  int'(en_pll),  p);
        chk({tag, ".en_pa"},   int'(en_pa),   a);
        chk({tag, ".pa_ramp"}, int'(ramp),    r);
        chk({tag, ".rdy_tx"},  int'(rdy),     y);
        chk({tag, ".err_tx"},  int'(err),     e);
    endtask

    task automatic chk_state(input string tag, input pwr_state_e exp);
        chk({tag, ".state"}, int'(state), int'(exp));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       pu;
        logic       lock;
        int         ticks;
        logic       bias;
        logic       pll;
        logic       pa;
        logic [3:0] ramp;
        logic       rdy;
        logic       err;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs[NV];

    initial begin
        // Normal power-up, LOCK rises 7 cycles after EN_PLL, then power-down.
        //           pu    lock  ticks bias  pll   pa    ramp   rdy   err
        vecs[0]  = '{1'b1, 1'b0, 2,  1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0}; // edge 2
        vecs[1]  = '{1'b1, 1'b0, 1,  1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0}; // 3: bias
        vecs[2]  = '{1'b1, 1'b0, 19, 1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0}; // 22
        vecs[3]  = '{1'b1, 1'b0, 1,  1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0}; // 23: pll
        vecs[4]  = '{1'b1, 1'b0, 7,  1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0}; // 30
        vecs[5]  = '{1'b1, 1'b1, 1,  1'b1, 1'b1, 1'b1, 4'd0,  1'b0, 1'b0}; // 31: pa
        vecs[6]  = '{1'b1, 1'b1, 3,  1'b1, 1'b1, 1'b1, 4'd0,  1'b0, 1'b0}; // 34
        vecs[7]  = '{1'b1, 1'b1, 1,  1'b1, 1'b1, 1'b1, 4'd1,  1'b0, 1'b0}; // 35
        vecs[8]  = '{1'b1, 1'b1, 4,  1'b1, 1'b1, 1'b1, 4'd2,  1'b0, 1'b0}; // 39
        vecs[9]  = '{1'b1, 1'b1, 51, 1'b1, 1'b1, 1'b1, 4'd14, 1'b0, 1'b0}; // 90
        vecs[10] = '{1'b1, 1'b1, 1,  1'b1, 1'b1, 1'b1, 4'd15, 1'b1, 1'b0}; // 91: ready
        vecs[11] = '{1'b1, 1'b1, 5,  1'b1, 1'b1, 1'b1, 4'd15, 1'b1, 1'b0}; // 96
        vecs[12] = '{1'b0, 1'b1, 2,  1'b1, 1'b1, 1'b1, 4'd15, 1'b1, 1'b0}; // fall +2
        vecs[13] = '{1'b0, 1'b1, 1,  1'b1, 1'b1, 1'b1, 4'd15, 1'b0, 1'b0}; // +3
        vecs[14] = '{1'b0, 1'b1, 3,  1'b1, 1'b1, 1'b1, 4'd15, 1'b0, 1'b0}; // +6
        vecs[15] = '{1'b0, 1'b1, 1,  1'b1, 1'b1, 1'b1, 4'd14, 1'b0, 1'b0}; // +7
        vecs[16] = '{1'b0, 1'b1, 55, 1'b1, 1'b1, 1'b1, 4'd1,  1'b0, 1'b0}; // +62
        vecs[17] = '{1'b0, 1'b1, 1,  1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0}; // +63: off
        vecs[18] = '{1'b0, 1'b1, 5,  1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0}; // +68

        // Reset state
        reset_dut();
        chk_outs("reset", 0, 0, 0, 0, 0, 0);
        chk_state("reset", OFF);

        for (int i = 0; i < NV; i++) begin
            pu   = vecs[i].pu;
            lock = vecs[i].lock;
            repeat (vecs[i].ticks) tick();
            chk_outs($sformatf("vec%0d", i), int'(vecs[i].bias), int'(vecs[i].pll),
                     int'(vecs[i].pa), int'(vecs[i].ramp), int'(vecs[i].rdy),
                     int'(vecs[i].err));
        end
        chk_state("vec_end", OFF);

        // Lock timeout: EN_PLL at 23, FAULT at 23+65 = 88.
        reset_dut();
        pu = 1'b1;
        repeat (23) tick();
        chk_outs("to_pll", 1, 1, 0, 0, 0, 0);
        repeat (64) tick();
        chk_outs("to_wait", 1, 1, 0, 0, 0, 0);
        tick();
        chk_outs("to_fault", 0, 0, 0, 0, 0, 1);
        chk_state("to_fault", FAULT);
        pu = 1'b0;
        repeat (2) tick();
        chk("to_hold.err_tx", int'(err), 1);
        tick();
        chk("to_clear.err_tx", int'(err), 0);
        chk_state("to_clear", OFF);

        // Lock loss at PA_RAMP=6: ramp 6->0 over 24 cycles, then FAULT.
        reset_dut();
        pu = 1'b1;
        repeat (30) tick();
        lock = 1'b1;
        tick();
        chk_outs("ll_up", 1, 1, 1, 0, 0, 0);
        repeat (24) tick();
        chk("ll_six.pa_ramp", int'(ramp), 6);
        lock = 1'b0;
        tick();
        chk_outs("ll_dn", 1, 1, 1, 6, 0, 0);
        chk_state("ll_dn", RAMP_DN);
        repeat (23) tick();
        chk_outs("ll_one", 1, 1, 1, 1, 0, 0);
        tick();
        chk_outs("ll_fault", 0, 0, 0, 0, 0, 1);
        chk_state("ll_fault", FAULT);
        pu = 1'b0;
        repeat (3) tick();
        chk("ll_clear.err_tx", int'(err), 0);

        // Request toggles low then high during RAMP_DN.
        reset_dut();
        pu   = 1'b1;
        lock = 1'b1;
        repeat (24) tick();
        chk_outs("tg_up", 1, 1, 1, 0, 0, 0);
        repeat (60) tick();
        chk_outs("tg_on", 1, 1, 1, 15, 1, 0);
        pu = 1'b0;
        repeat (3) tick();
        chk("tg_dn.rdy_tx", int'(rdy), 0);
        chk_state("tg_dn", RAMP_DN);
        pu = 1'b1;
        repeat (59) tick();
        chk_outs("tg_one", 1, 1, 1, 1, 0, 0);
        tick();
        chk_outs("tg_off", 0, 0, 0, 0, 0, 0);
        chk_state("tg_off", OFF);
        tick();
        chk_outs("tg_rebias", 1, 0, 0, 0, 0, 0);
        chk_state("tg_rebias", BIAS);
        pu = 1'b0;
        repeat (3) tick();
        chk("tg_abort.en_bias", int'(en_bias), 0);

        // Reset pulse while ON: everything off on the next edge.
        reset_dut();
        pu   = 1'b1;
        lock = 1'b1;
        repeat (84) tick();
        chk("rs_on.rdy_tx", int'(rdy), 1);
        rst = 1'b1;
        pu  = 1'b0;
        tick();
        chk_outs("rs_hit", 0, 0, 0, 0, 0, 0);
        chk_state("rs_hit", OFF);
        rst = 1'b0;
        repeat (3) tick();
        chk_outs("rs_after", 0, 0, 0, 0, 0, 0);

        // Request glitch between clock edges never reaches the synchroniser.
        reset_dut();
        tick();
        pu = 1'b1;
        #3;
        pu = 1'b0;
        repeat (6) tick();
        chk("gl.en_bias", int'(en_bias), 0);
        chk_state("gl", OFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
